// File: rtl/biu_timegen_pbank.sv
// SDRAM bus-interface timing generator: sequences PRECHARGE/ACTIVATE/READ/WRITE/WAIT
// phases on a programmable down-timer, tracks the open row per bank and schedules auto-refresh.
module biu_timegen_pbank #(
  parameter int TIMER_BITS = 8,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_BITS  = 2,
  parameter int ROW_BITS   = 13,
  parameter int REF_BITS   = 12
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic                  CmdValid,
  output logic                  CmdReady,
  input  logic                  CmdWrite,
  input  logic [BANK_BITS-1:0]  CmdBank,
  input  logic [ROW_BITS-1:0]   CmdRow,
  input  logic [2:0]            CmdBurst,
  input  logic                  BurstStop,
  input  logic [TIMER_BITS-1:0] tpre,
  input  logic [TIMER_BITS-1:0] tcas,
  input  logic [3:0]            tlat,
  input  logic [TIMER_BITS-1:0] twait,
  input  logic [TIMER_BITS-1:0] trfc,
  input  logic [REF_BITS-1:0]   trefi,
  output logic [2:0]            StateOut,
  output logic [TIMER_BITS-1:0] TimerCountOut,
  output logic                  TimerLd,
  output logic                  RwState,
  output logic                  PageHit,
  output logic                  RefBusy,
  output logic                  Done
);

  localparam int DW = TIMER_BITS + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ACT   = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4,
    S_WAIT  = 3'd5,
    S_REF   = 3'd6
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [TIMER_BITS-1:0] timer_nx;
  logic                  ld_nx;
  logic                  done_nx;
  logic                  rw_nx;
  logic                  hit_nx;
  logic                  busy_nx;
  logic [NUM_BANKS-1:0]  bank_open;
  logic [NUM_BANKS-1:0]  open_nx;
  logic [ROW_BITS-1:0]   bank_row [NUM_BANKS];
  logic                  row_we;
  logic                  cmd_take;
  logic [BANK_BITS-1:0]  cmd_bank;
  logic [ROW_BITS-1:0]   cmd_row;
  logic [2:0]            cmd_burst;
  logic                  ref_pending;
  logic [REF_BITS-1:0]   ref_cnt;
  logic                  ref_set;
  logic                  ref_clr;
  logic                  burst_end;
  logic [TIMER_BITS-1:0] pre_load;
  logic [TIMER_BITS-1:0] act_load;
  logic [TIMER_BITS-1:0] ref_load;
  logic [TIMER_BITS-1:0] wait_load;
  logic [TIMER_BITS-1:0] new_rw_load;
  logic [TIMER_BITS-1:0] act_rw_load;
  logic [TIMER_BITS-1:0] timer_dec;

  function automatic logic [DW-1:0] beats_of(input logic [2:0] code);
    case (code)
      3'd7:    beats_of = DW'(255);
      default: beats_of = DW'(1) << code;
    endcase
  endfunction

  // Load value is duration-1, saturated to the timer range.
  function automatic logic [TIMER_BITS-1:0] load_of(input logic [DW-1:0] dur);
    logic [DW-1:0] dm1;
    dm1 = dur - DW'(1);
    if (dm1[TIMER_BITS]) begin
      load_of = '1;
    end else begin
      load_of = dm1[TIMER_BITS-1:0];
    end
  endfunction

  function automatic logic [TIMER_BITS-1:0] rw_load(input logic wr, input logic [2:0] code,
                                                    input logic [3:0] lat);
    if (wr) begin
      rw_load = load_of(beats_of(code));
    end else begin
      rw_load = load_of(DW'(lat) + beats_of(code));
    end
  endfunction

  assign pre_load    = load_of({1'b0, tpre} + DW'(1));
  assign act_load    = load_of({1'b0, tcas} + DW'(1));
  assign ref_load    = load_of({1'b0, trfc} + DW'(1));
  assign wait_load   = load_of({1'b0, twait});
  assign new_rw_load = rw_load(CmdWrite, CmdBurst, tlat);
  assign act_rw_load = rw_load(RwState, cmd_burst, tlat);
  assign timer_dec   = TimerCountOut - TIMER_BITS'(1);
  assign burst_end   = (TimerCountOut == '0) || BurstStop;
  assign ref_set     = (trefi != '0) && (ref_cnt == '0);

  assign CmdReady = En & (state == S_IDLE) & ~ref_pending & Rst;
  assign StateOut = state;

  // Next-phase selection, timer loading and open-row bookkeeping.
  always_comb begin
    state_nx = state;
    timer_nx = TimerCountOut;
    ld_nx    = 1'b0;
    done_nx  = 1'b0;
    rw_nx    = RwState;
    hit_nx   = PageHit;
    busy_nx  = RefBusy;
    open_nx  = bank_open;
    row_we   = 1'b0;
    cmd_take = 1'b0;
    ref_clr  = 1'b0;
    case (state)
      S_IDLE: begin
        timer_nx = '0;
        if (ref_pending) begin
          busy_nx = 1'b1;
          ld_nx   = 1'b1;
          if (|bank_open) begin
            state_nx = S_PRE;
            timer_nx = pre_load;
          end else begin
            state_nx = S_REF;
            timer_nx = ref_load;
            open_nx  = '0;
            ref_clr  = 1'b1;
          end
        end else if (CmdValid) begin
          cmd_take = 1'b1;
          rw_nx    = CmdWrite;
          ld_nx    = 1'b1;
          if (bank_open[CmdBank] && (bank_row[CmdBank] == CmdRow)) begin
            hit_nx   = 1'b1;
            state_nx = CmdWrite ? S_WRITE : S_READ;
            timer_nx = new_rw_load;
          end else if (bank_open[CmdBank]) begin
            hit_nx   = 1'b0;
            state_nx = S_PRE;
            timer_nx = pre_load;
          end else begin
            hit_nx   = 1'b0;
            state_nx = S_ACT;
            timer_nx = act_load;
          end
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_PRE: begin
        if (TimerCountOut == '0) begin
          ld_nx = 1'b1;
          if (RefBusy) begin
            state_nx = S_REF;
            timer_nx = ref_load;
            open_nx  = '0;
            ref_clr  = 1'b1;
          end else begin
            open_nx[cmd_bank] = 1'b0;
            state_nx          = S_ACT;
            timer_nx          = act_load;
          end
        end else begin
          timer_nx = timer_dec;
        end
      end
      S_ACT: begin
        if (TimerCountOut == '0) begin
          open_nx[cmd_bank] = 1'b1;
          row_we            = 1'b1;
          ld_nx             = 1'b1;
          state_nx          = RwState ? S_WRITE : S_READ;
          timer_nx          = act_rw_load;
        end else begin
          timer_nx = timer_dec;
        end
      end
      S_READ, S_WRITE: begin
        if (burst_end) begin
          if (twait != '0) begin
            state_nx = S_WAIT;
            timer_nx = wait_load;
            ld_nx    = 1'b1;
          end else begin
            state_nx = S_IDLE;
            timer_nx = '0;
            done_nx  = 1'b1;
          end
        end else begin
          timer_nx = timer_dec;
        end
      end
      S_WAIT: begin
        if (TimerCountOut == '0) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end else begin
          timer_nx = timer_dec;
        end
      end
      S_REF: begin
        if (TimerCountOut == '0) begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
        end else begin
          timer_nx = timer_dec;
        end
      end
      default: begin
        state_nx = S_IDLE;
        timer_nx = '0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // Phase state, registered outputs, latched command and per-bank row table.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state         <= S_IDLE;
      TimerCountOut <= '0;
      TimerLd       <= 1'b0;
      Done          <= 1'b0;
      RwState       <= 1'b0;
      PageHit       <= 1'b0;
      RefBusy       <= 1'b0;
      bank_open     <= '0;
      cmd_bank      <= '0;
      cmd_row       <= '0;
      cmd_burst     <= 3'd0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_row[i] <= '0;
      end
    end else if (En) begin
      state         <= state_nx;
      TimerCountOut <= timer_nx;
      TimerLd       <= ld_nx;
      Done          <= done_nx;
      RwState       <= rw_nx;
      PageHit       <= hit_nx;
      RefBusy       <= busy_nx;
      bank_open     <= open_nx;
      if (cmd_take) begin
        cmd_bank  <= CmdBank;
        cmd_row   <= CmdRow;
        cmd_burst <= CmdBurst;
      end
      if (row_we) begin
        bank_row[cmd_bank] <= cmd_row;
      end
    end
  end

  // Refresh interval counter; a new request wins over a same-cycle clear.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      ref_cnt     <= trefi;
      ref_pending <= 1'b0;
    end else if (En) begin
      if (trefi != '0) begin
        if (ref_cnt == '0) begin
          ref_cnt <= trefi;
        end else begin
          ref_cnt <= ref_cnt - REF_BITS'(1);
        end
      end
      if (ref_set) begin
        ref_pending <= 1'b1;
      end else if (ref_clr) begin
        ref_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_biu_timegen_pbank.sv
// Directed scoreboard bench: stimulus queues hand-computed phase entries and Done
// pulses; a forked monitor pops and compares on each fresh TimerLd/Done.
module tb_biu_timegen_pbank;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        En = 1'b1;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic        CmdWrite = 1'b0;
  logic [1:0]  CmdBank = 2'd0;
  logic [12:0] CmdRow = 13'd0;
  logic [2:0]  CmdBurst = 3'd0;
  logic        BurstStop = 1'b0;
  logic [7:0]  tpre = 8'd2;
  logic [7:0]  tcas = 8'd3;
  logic [3:0]  tlat = 4'd2;
  logic [7:0]  twait = 8'd1;
  logic [7:0]  trfc = 8'd4;
  logic [11:0] trefi = 12'd0;
  logic [2:0]  StateOut;
  logic [7:0]  TimerCountOut;
  logic        TimerLd;
  logic        RwState;
  logic        PageHit;
  logic        RefBusy;
  logic        Done;

  biu_timegen_pbank dut (
    .Clk(Clk), .Rst(Rst), .En(En), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdWrite(CmdWrite), .CmdBank(CmdBank), .CmdRow(CmdRow), .CmdBurst(CmdBurst),
    .BurstStop(BurstStop), .tpre(tpre), .tcas(tcas), .tlat(tlat), .twait(twait),
    .trfc(trfc), .trefi(trefi), .StateOut(StateOut), .TimerCountOut(TimerCountOut),
    .TimerLd(TimerLd), .RwState(RwState), .PageHit(PageHit), .RefBusy(RefBusy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int   cyc = 0;
  logic en_last = 1'b0;
  always @(posedge Clk) begin
    cyc     <= cyc + 1;
    en_last <= En;
  end

  typedef struct {
    int          cyc;
    logic [15:0] v;
  } ev_t;

  ev_t         q[$];
  ev_t         mon_e;
  logic [15:0] mon_act;
  int          n_vec = 0;
  int          n_fail = 0;
  int          acc;
  int          r0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic ph_ev(input int c, input logic [2:0] st, input logic [7:0] tm,
                       input logic rw, input logic ph, input logic rb);
    ev_t e;
    e.cyc = c;
    e.v   = {st, tm, 1'b1, 1'b0, rw, ph, rb};
    q.push_back(e);
  endtask

  task automatic dn_ev(input int c, input logic rw, input logic ph);
    ev_t e;
    e.cyc = c;
    e.v   = {3'd0, 8'd0, 1'b0, 1'b1, rw, ph, 1'b0};
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [11:0] ri, output int r);
    @(negedge Clk);
    Rst   = 1'b0;
    trefi = ri;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk("reset_outputs", 32'({StateOut, TimerCountOut, TimerLd, RwState, PageHit, RefBusy, Done}), 32'd0);
    chk("reset_ready", 32'(CmdReady), 32'd0);
    r = cyc;
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  // Call right after a negedge; returns the acceptance cycle.
  task automatic issue(input logic wr, input logic [1:0] bk, input logic [12:0] row,
                       input logic [2:0] bu, output int a);
    int waited;
    waited   = 0;
    CmdValid = 1'b1;
    CmdWrite = wr;
    CmdBank  = bk;
    CmdRow   = row;
    CmdBurst = bu;
    #1;
    while (CmdReady !== 1'b1 && waited < 100) begin
      @(negedge Clk);
      #1;
      waited++;
    end
    chk("accept", 32'(CmdReady), 32'd1);
    a = cyc;
    @(posedge Clk);
    #1;
    CmdValid = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge Clk);
        if (en_last === 1'b1 && (TimerLd === 1'b1 || Done === 1'b1)) begin
          mon_act = {StateOut, TimerCountOut, TimerLd, Done, RwState, PageHit, RefBusy};
          n_vec++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event cyc=%0d got {st,tm,ld,dn,rw,ph,rb}=%h", cyc, mon_act);
          end else begin
            mon_e = q.pop_front();
            if (mon_act !== mon_e.v || cyc != mon_e.cyc) begin
              n_fail++;
              $display("FAIL phase_event got cyc=%0d {st,tm,ld,dn,rw,ph,rb}=%h expected cyc=%0d %h",
                       cyc, mon_act, mon_e.cyc, mon_e.v);
            end
          end
        end
      end
    join_none

    do_reset(12'd0, r0);

    // Closed-bank read, 4 beats, one wait cycle.
    issue(1'b0, 2'd1, 13'h123, 3'd2, acc);
    ph_ev(acc + 1, 3'd2, 8'd3, 1'b0, 1'b0, 1'b0);
    ph_ev(acc + 5, 3'd3, 8'd5, 1'b0, 1'b0, 1'b0);
    ph_ev(acc + 11, 3'd5, 8'd0, 1'b0, 1'b0, 1'b0);
    dn_ev(acc + 12, 1'b0, 1'b0);
    step(12);
    twait = 8'd0;

    // Page-hit single-beat write.
    @(negedge Clk);
    issue(1'b1, 2'd1, 13'h123, 3'd0, acc);
    ph_ev(acc + 1, 3'd4, 8'd0, 1'b1, 1'b1, 1'b0);
    dn_ev(acc + 2, 1'b1, 1'b1);
    step(2);

    // Page miss; BurstStop held through PRECHARGE/ACTIVATE must be ignored.
    @(negedge Clk);
    issue(1'b0, 2'd1, 13'h0AB, 3'd1, acc);
    ph_ev(acc + 1, 3'd1, 8'd2, 1'b0, 1'b0, 1'b0);
    ph_ev(acc + 4, 3'd2, 8'd3, 1'b0, 1'b0, 1'b0);
    ph_ev(acc + 8, 3'd3, 8'd3, 1'b0, 1'b0, 1'b0);
    dn_ev(acc + 12, 1'b0, 1'b0);
    BurstStop = 1'b1;
    step(6);
    BurstStop = 1'b0;
    step(6);

    // The new row is now open in bank 1.
    @(negedge Clk);
    issue(1'b0, 2'd1, 13'h0AB, 3'd1 - 3'd1, acc);
    ph_ev(acc + 1, 3'd3, 8'd2, 1'b0, 1'b1, 1'b0);
    dn_ev(acc + 4, 1'b0, 1'b1);
    step(4);
    twait = 8'd3;

    // Full-page read: saturated load, then BurstStop in its second cycle.
    @(negedge Clk);
    issue(1'b0, 2'd1, 13'h0AB, 3'd7, acc);
    ph_ev(acc + 1, 3'd3, 8'd255, 1'b0, 1'b1, 1'b0);
    ph_ev(acc + 3, 3'd5, 8'd2, 1'b0, 1'b1, 1'b0);
    dn_ev(acc + 6, 1'b0, 1'b1);
    step(1);
    BurstStop = 1'b1;
    step(1);
    BurstStop = 1'b0;
    step(5);
    twait = 8'd0;

    // En low for three cycles in ACTIVATE, then reset in the middle of READ.
    @(negedge Clk);
    issue(1'b0, 2'd2, 13'h005, 3'd0, acc);
    ph_ev(acc + 1, 3'd2, 8'd3, 1'b0, 1'b0, 1'b0);
    ph_ev(acc + 8, 3'd3, 8'd2, 1'b0, 1'b0, 1'b0);
    step(1);
    En = 1'b0;
    step(2);
    @(negedge Clk);
    chk("en_hold_state", 32'(StateOut), 32'd2);
    chk("en_hold_timer", 32'(TimerCountOut), 32'd2);
    chk("en_hold_ld", 32'(TimerLd), 32'd0);
    @(posedge Clk);
    #1;
    En = 1'b1;
    step(4);
    Rst = 1'b0;
    step(1);
    Rst = 1'b1;
    #1;
    chk("midread_reset_state", 32'({StateOut, TimerCountOut, Done}), 32'd0);
    chk("midread_reset_ready", 32'(CmdReady), 32'd1);
    @(negedge Clk);
    issue(1'b0, 2'd2, 13'h005, 3'd0, acc);
    ph_ev(acc + 1, 3'd2, 8'd3, 1'b0, 1'b0, 1'b0);
    ph_ev(acc + 5, 3'd3, 8'd2, 1'b0, 1'b0, 1'b0);
    dn_ev(acc + 8, 1'b0, 1'b0);
    step(9);

    // Refresh with bank 0 open and a command held waiting.
    do_reset(12'd20, r0);
    issue(1'b1, 2'd0, 13'h007, 3'd0, acc);
    ph_ev(acc + 1, 3'd2, 8'd3, 1'b1, 1'b0, 1'b0);
    ph_ev(acc + 5, 3'd4, 8'd0, 1'b1, 1'b0, 1'b0);
    dn_ev(acc + 6, 1'b1, 1'b0);
    while (cyc < r0 + 21) @(negedge Clk);
    ph_ev(r0 + 22, 3'd1, 8'd2, 1'b1, 1'b0, 1'b1);
    ph_ev(r0 + 25, 3'd6, 8'd4, 1'b1, 1'b0, 1'b1);
    chk("refresh_blocks_ready", 32'(CmdReady), 32'd0);
    issue(1'b0, 2'd0, 13'h007, 3'd0, acc);
    chk("refresh_accept_cycle", 32'(acc - r0), 32'd30);
    ph_ev(acc + 1, 3'd2, 8'd3, 1'b0, 1'b0, 1'b0);
    ph_ev(acc + 5, 3'd3, 8'd2, 1'b0, 1'b0, 1'b0);
    dn_ev(acc + 8, 1'b0, 1'b0);
    step(9);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
